// File: rtl/lemming_world.sv
// Terrain model for the Lemmings walker: tracks the lemming on a
// grid with holes and diggable floors and feeds back bump/ground.
module lemming_world #(
    parameter int             W            = 16,
    parameter int             DEPTH        = 4,
    parameter int             START_X      = 5,
    parameter logic [W-1:0]   HOLE_MASK    = 16'h0100,
    parameter int             DIG_CYCLES   = 4,
    parameter int             SPLAT_LEVELS = 2,
    parameter int             EXIT_X       = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     walk_left,
    input  logic                     walk_right,
    input  logic                     aaah,
    input  logic                     digging,
    output logic                     bump_left,
    output logic                     bump_right,
    output logic                     ground,
    output logic [$clog2(W)-1:0]     pos_x,
    output logic [$clog2(DEPTH)-1:0] pos_y,
    output logic                     splat,
    output logic                     exited,
    output logic                     proto_err
);

    localparam int XW = $clog2(W);
    localparam int YW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(DIG_CYCLES + 1);

    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [XW-1:0] X_MAX   = XW'(W - 1);
    localparam logic [XW-1:0] X_EXIT  = XW'(EXIT_X);
    localparam logic [YW-1:0] Y_BOT   = YW'(DEPTH - 1);
    localparam logic [FW-1:0] F_MAX   = FW'(DEPTH);
    localparam logic [FW-1:0] F_SPLAT = FW'(SPLAT_LEVELS);
    localparam logic [DW-1:0] D_LAST  = DW'(DIG_CYCLES - 1);

    logic [XW-1:0]               r_pos_x;
    logic [YW-1:0]               r_pos_y;
    logic [DEPTH-1:0][W-1:0]     r_dug;
    logic [DW-1:0]               r_dig_cnt;
    logic [FW-1:0]               r_fall_cnt;
    logic                        r_splat;
    logic                        r_exited;
    logic                        r_proto_err;

    logic                        w_ground;
    logic                        w_one;
    logic                        w_multi;
    logic                        w_frozen;
    logic                        w_at_exit;

    // Floor under the registered position; the bottom level is solid.
    always_comb begin
        w_ground = 1'b1;
        if (r_pos_y == Y_BOT) begin
            w_ground = 1'b1;
        end else if (r_pos_y == '0) begin
            w_ground = !HOLE_MASK[r_pos_x] && !r_dug[0][r_pos_x];
        end else begin
            w_ground = !r_dug[r_pos_y][r_pos_x];
        end
    end

    assign w_one    = $onehot({walk_left, walk_right, aaah, digging});
    assign w_multi  = !$onehot0({walk_left, walk_right, aaah, digging});
    assign w_frozen = r_splat || r_exited;
    // Standing on the exit (not mid-landing) ends the walk in place.
    assign w_at_exit = (r_pos_x == X_EXIT) && (r_pos_y == Y_BOT)
                       && w_ground && !aaah;

    // Position, dig map, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pos_x     <= X_START;
            r_pos_y     <= '0;
            r_dug       <= '0;
            r_dig_cnt   <= '0;
            r_fall_cnt  <= '0;
            r_splat     <= 1'b0;
            r_exited    <= 1'b0;
            r_proto_err <= 1'b0;
        end else if (!w_frozen) begin
            if (w_at_exit) begin
                r_exited <= 1'b1;
            end else begin
                if (w_multi) begin
                    r_proto_err <= 1'b1;
                end
                if (!w_one) begin
                    r_dig_cnt <= '0;
                end else if (walk_left) begin
                    r_dig_cnt <= '0;
                    if (w_ground && r_pos_x != '0) begin
                        r_pos_x <= r_pos_x - 1'b1;
                    end
                end else if (walk_right) begin
                    r_dig_cnt <= '0;
                    if (w_ground && r_pos_x != X_MAX) begin
                        r_pos_x <= r_pos_x + 1'b1;
                    end
                end else if (aaah) begin
                    r_dig_cnt <= '0;
                    if (!w_ground) begin
                        r_pos_y <= r_pos_y + 1'b1;
                        if (r_fall_cnt != F_MAX) begin
                            r_fall_cnt <= r_fall_cnt + 1'b1;
                        end
                    end else begin
                        if (r_fall_cnt > F_SPLAT) begin
                            r_splat <= 1'b1;
                        end
                        r_fall_cnt <= '0;
                    end
                end else begin
                    if (w_ground && r_pos_y != Y_BOT) begin
                        if (r_dig_cnt == D_LAST) begin
                            r_dug[r_pos_y][r_pos_x] <= 1'b1;
                            r_dig_cnt <= '0;
                        end else begin
                            r_dig_cnt <= r_dig_cnt + 1'b1;
                        end
                    end else begin
                        r_dig_cnt <= '0;
                    end
                end
            end
        end
    end

    assign bump_left  = (r_pos_x == '0);
    assign bump_right = (r_pos_x == X_MAX);
    assign ground     = w_ground;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign splat      = r_splat;
    assign exited     = r_exited;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: directed scenarios plus a randomized
// run against a behavioural grid model.
module tb_lemming_world;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int SX    = 5;
    localparam int DIGN  = 4;
    localparam int SPL   = 2;
    localparam int EX    = 12;
    localparam logic [15:0] HOLE = 16'h0100;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wl = 1'b0, wr = 1'b0, fa = 1'b0, dg = 1'b0;
    logic       bump_left, bump_right, ground;
    logic [3:0] pos_x;
    logic [1:0] pos_y;
    logic       splat, exited, proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    int m_x, m_y, m_fc, m_dc;
    bit m_dug [DEPTH][W];
    bit m_sp, m_ex, m_pe;

    lemming_world dut (
        .clk        (clk),
        .resetn     (resetn),
        .walk_left  (wl),
        .walk_right (wr),
        .aaah       (fa),
        .digging    (dg),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .splat      (splat),
        .exited     (exited),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    function automatic bit mfloor(input int x, input int y);
        if (y == DEPTH - 1) return 1'b1;
        if (y == 0) return !HOLE[x] && !m_dug[0][x];
        return !m_dug[y][x];
    endfunction

    task automatic model_step(input bit rst, input bit l, input bit r,
                              input bit f, input bit d);
        bit g;
        int n;
        if (!rst) begin
            m_x = SX; m_y = 0; m_fc = 0; m_dc = 0;
            m_sp = 0; m_ex = 0; m_pe = 0;
            for (int y = 0; y < DEPTH; y++)
                for (int x = 0; x < W; x++) m_dug[y][x] = 0;
            return;
        end
        if (m_sp || m_ex) return;
        g = mfloor(m_x, m_y);
        n = int'(l) + int'(r) + int'(f) + int'(d);
        if (m_x == EX && m_y == DEPTH - 1 && g && !f) begin
            m_ex = 1;
            return;
        end
        if (n > 1) m_pe = 1;
        if (n != 1) begin
            m_dc = 0;
        end else if (l) begin
            m_dc = 0;
            if (g && m_x > 0) m_x--;
        end else if (r) begin
            m_dc = 0;
            if (g && m_x < W - 1) m_x++;
        end else if (f) begin
            m_dc = 0;
            if (!g) begin
                m_y++;
                if (m_fc < DEPTH) m_fc++;
            end else begin
                if (m_fc > SPL) m_sp = 1;
                m_fc = 0;
            end
        end else begin
            if (g && m_y < DEPTH - 1) begin
                m_dc++;
                if (m_dc == DIGN) begin
                    m_dug[m_y][m_x] = 1;
                    m_dc = 0;
                end
            end else begin
                m_dc = 0;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit l, input bit r,
                        input bit f, input bit d);
        resetn = rst; wl = l; wr = r; fa = f; dg = d;
        @(posedge clk);
        model_step(rst, l, r, f, d);
        #1;
        resetn = 1'b1; wl = 0; wr = 0; fa = 0; dg = 0;
    endtask

    task automatic run(input int n, input bit l, input bit r,
                       input bit f, input bit d);
        for (int i = 0; i < n; i++) tick(1, l, r, f, d);
    endtask

    task automatic test_reset;
        tick(0, 1, 1, 1, 1);
        n_checks++;
        if (pos_x !== 4'd5) $display("FAIL reset_x got %0d want 5", pos_x);
        else n_pass++;
        n_checks++;
        if (pos_y !== 2'd0) $display("FAIL reset_y got %0d want 0", pos_y);
        else n_pass++;
        n_checks++;
        if ({bump_left, bump_right, ground} !== 3'b001)
            $display("FAIL reset_bgr got %b want 001",
                     {bump_left, bump_right, ground});
        else n_pass++;
        n_checks++;
        if ({splat, exited, proto_err} !== 3'b000)
            $display("FAIL reset_flags got %b want 000",
                     {splat, exited, proto_err});
        else n_pass++;
        run(2, 0, 0, 0, 0);
        n_checks++;
        if ({pos_x, proto_err} !== {4'd5, 1'b0})
            $display("FAIL idle got x=%0d pe=%b want x=5 pe=0",
                     pos_x, proto_err);
        else n_pass++;
    endtask

    task automatic test_walk_left;
        int e;
        tick(0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            run(1, 1, 0, 0, 0);
            e = (SX - k < 0) ? 0 : SX - k;
            n_checks++;
            if ({pos_x, bump_left} !== {4'(e), e == 0})
                $display("FAIL walk_left k=%0d got x=%0d bl=%b want x=%0d bl=%b",
                         k, pos_x, bump_left, e, e == 0);
            else n_pass++;
        end
    endtask

    task automatic test_walk_right_hole;
        tick(0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            run(1, 0, 1, 0, 0);
            n_checks++;
            if ({pos_x, ground} !== {4'(SX + k), k != 3})
                $display("FAIL walk_right k=%0d got x=%0d g=%b want x=%0d g=%b",
                         k, pos_x, ground, SX + k, k != 3);
            else n_pass++;
        end
        run(1, 0, 1, 0, 0);
        n_checks++;
        if ({pos_x, pos_y} !== {4'd8, 2'd0})
            $display("FAIL hole_hold got (%0d,%0d) want (8,0)", pos_x, pos_y);
        else n_pass++;
        run(1, 0, 0, 1, 0);
        n_checks++;
        if ({pos_y, ground} !== {2'd1, 1'b1})
            $display("FAIL fall1 got y=%0d g=%b want y=1 g=1", pos_y, ground);
        else n_pass++;
        run(1, 0, 0, 1, 0);
        n_checks++;
        if ({pos_x, pos_y, splat} !== {4'd8, 2'd1, 1'b0})
            $display("FAIL land1 got (%0d,%0d) s=%b want (8,1) s=0",
                     pos_x, pos_y, splat);
        else n_pass++;
    endtask

    task automatic test_dig;
        tick(0, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0);
        run(3, 0, 0, 0, 1);
        run(1, 0, 0, 0, 0);
        run(3, 0, 0, 0, 1);
        n_checks++;
        if (ground !== 1'b1)
            $display("FAIL dig_interrupt got g=%b want 1", ground);
        else n_pass++;
        run(1, 0, 0, 0, 1);
        n_checks++;
        if (ground !== 1'b0)
            $display("FAIL dig_resume got g=%b want 0", ground);
        else n_pass++;
        tick(0, 0, 0, 0, 0);
        run(2, 1, 0, 0, 0);
        run(3, 0, 0, 0, 1);
        n_checks++;
        if ({pos_x, ground} !== {4'd3, 1'b1})
            $display("FAIL dig3 got x=%0d g=%b want x=3 g=1", pos_x, ground);
        else n_pass++;
        run(1, 0, 0, 0, 1);
        n_checks++;
        if (ground !== 1'b0)
            $display("FAIL dig4 got g=%b want 0", ground);
        else n_pass++;
        run(3, 0, 0, 0, 0);
        run(1, 0, 1, 0, 0);
        n_checks++;
        if ({pos_x, pos_y, ground} !== {4'd3, 2'd0, 1'b0})
            $display("FAIL dug_persist got (%0d,%0d) g=%b want (3,0) g=0",
                     pos_x, pos_y, ground);
        else n_pass++;
    endtask

    task automatic test_splat;
        tick(0, 0, 0, 0, 0);
        for (int lv = 0; lv < 3; lv++) begin
            run(DIGN, 0, 0, 0, 1);
            run(1, 0, 0, 1, 0);
            n_checks++;
            if ({pos_y, ground, splat} !== {2'(lv + 1), 1'b1, 1'b0})
                $display("FAIL chain lv=%0d got y=%0d g=%b s=%b want y=%0d g=1 s=0",
                         lv, pos_y, ground, splat, lv + 1);
            else n_pass++;
        end
        run(1, 0, 0, 1, 0);
        n_checks++;
        if (splat !== 1'b1)
            $display("FAIL splat3 got %b want 1", splat);
        else n_pass++;
        run(3, 1, 0, 0, 0);
        run(1, 1, 0, 0, 1);
        n_checks++;
        if ({pos_x, pos_y, splat, proto_err} !== {4'd5, 2'd3, 1'b1, 1'b0})
            $display("FAIL frozen got (%0d,%0d) s=%b pe=%b want (5,3) s=1 pe=0",
                     pos_x, pos_y, splat, proto_err);
        else n_pass++;
    endtask

    task automatic test_fall_boundary;
        tick(0, 0, 0, 0, 0);
        run(DIGN, 0, 0, 0, 1);
        run(1, 0, 0, 1, 0);
        run(DIGN, 0, 0, 0, 1);
        run(1, 0, 0, 1, 0);
        run(1, 0, 0, 1, 0);
        n_checks++;
        if ({pos_y, splat} !== {2'd2, 1'b0})
            $display("FAIL fall2 got y=%0d s=%b want y=2 s=0", pos_y, splat);
        else n_pass++;
        run(DIGN, 0, 0, 0, 1);
        run(2, 0, 0, 1, 0);
        n_checks++;
        if ({pos_y, splat} !== {2'd3, 1'b0})
            $display("FAIL fall_reset got y=%0d s=%b want y=3 s=0", pos_y, splat);
        else n_pass++;
    endtask

    task automatic test_reset_midfall;
        tick(0, 0, 0, 0, 0);
        run(DIGN, 0, 0, 0, 1);
        run(1, 0, 0, 1, 0);
        run(DIGN, 0, 0, 0, 1);
        run(1, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        n_checks++;
        if ({pos_x, pos_y, ground, splat} !== {4'd5, 2'd0, 1'b1, 1'b0})
            $display("FAIL midfall_rst got (%0d,%0d) g=%b s=%b want (5,0) g=1 s=0",
                     pos_x, pos_y, ground, splat);
        else n_pass++;
        run(DIGN, 0, 0, 0, 1);
        run(1, 0, 0, 1, 0);
        n_checks++;
        if ({pos_y, ground} !== {2'd1, 1'b1})
            $display("FAIL dug_cleared got y=%0d g=%b want y=1 g=1", pos_y, ground);
        else n_pass++;
        run(DIGN, 0, 0, 0, 1);
        run(2, 0, 0, 1, 0);
        n_checks++;
        if ({pos_y, splat} !== {2'd2, 1'b0})
            $display("FAIL fcnt_cleared got y=%0d s=%b want y=2 s=0", pos_y, splat);
        else n_pass++;
    endtask

    task automatic test_proto;
        tick(0, 0, 0, 0, 0);
        run(2, 0, 0, 0, 1);
        run(1, 1, 0, 0, 1);
        n_checks++;
        if ({pos_x, proto_err} !== {4'd5, 1'b1})
            $display("FAIL proto got x=%0d pe=%b want x=5 pe=1", pos_x, proto_err);
        else n_pass++;
        run(3, 0, 0, 0, 1);
        n_checks++;
        if ({ground, proto_err} !== 2'b11)
            $display("FAIL proto_dclr got g=%b pe=%b want g=1 pe=1",
                     ground, proto_err);
        else n_pass++;
        run(1, 0, 0, 0, 1);
        n_checks++;
        if ({ground, proto_err} !== 2'b01)
            $display("FAIL proto_sticky got g=%b pe=%b want g=0 pe=1",
                     ground, proto_err);
        else n_pass++;
    endtask

    task automatic test_exit;
        tick(0, 0, 0, 0, 0);
        run(2, 0, 1, 0, 0);
        for (int lv = 0; lv < 3; lv++) begin
            run(DIGN, 0, 0, 0, 1);
            run(2, 0, 0, 1, 0);
        end
        run(4, 0, 1, 0, 0);
        n_checks++;
        if ({pos_x, pos_y, exited, splat} !== {4'd11, 2'd3, 1'b0, 1'b0})
            $display("FAIL pre_exit got (%0d,%0d) e=%b s=%b want (11,3) e=0 s=0",
                     pos_x, pos_y, exited, splat);
        else n_pass++;
        run(1, 0, 1, 0, 0);
        n_checks++;
        if ({pos_x, exited} !== {4'd12, 1'b0})
            $display("FAIL at_exit got x=%0d e=%b want x=12 e=0", pos_x, exited);
        else n_pass++;
        run(3, 0, 1, 0, 0);
        n_checks++;
        if ({pos_x, exited} !== {4'd12, 1'b1})
            $display("FAIL exited got x=%0d e=%b want x=12 e=1", pos_x, exited);
        else n_pass++;
    endtask

    task automatic test_random;
        int r, k;
        bit l, rr, f, d, rst;
        logic [11:0] want;
        tick(0, 0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            l = 0; rr = 0; f = 0; d = 0; rst = 1;
            if (r < 2) begin
                rst = 0;
            end else if (!mfloor(m_x, m_y) && r < 80) begin
                f = 1;
            end else begin
                k = $urandom_range(0, 11);
                if (k < 3) l = 1;
                else if (k < 6) rr = 1;
                else if (k < 8) f = 1;
                else if (k < 11) d = 1;
                else {l, rr, f, d} = 4'($urandom);
            end
            tick(rst, l, rr, f, d);
            want = {4'(m_x), 2'(m_y), m_x == 0, m_x == W - 1,
                    mfloor(m_x, m_y), m_sp, m_ex, m_pe};
            n_checks++;
            if ({pos_x, pos_y, bump_left, bump_right, ground,
                 splat, exited, proto_err} !== want)
                $display("FAIL random c=%0d got %h want %h", c,
                         {pos_x, pos_y, bump_left, bump_right, ground,
                          splat, exited, proto_err}, want);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_walk_left;
        test_walk_right_hole;
        test_dig;
        test_splat;
        test_fall_boundary;
        test_reset_midfall;
        test_proto;
        test_exit;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
